// File: rtl/sr_sipo_4bit_rx_if.sv
// Serial receive link bundle: bit stream and control in, assembled word and status out.
interface sr_sipo_4bit_rx_if #(
  parameter int unsigned WIDTH = 4
) ();
  localparam int unsigned CW = $clog2(WIDTH);

  logic             sin;
  logic             sin_en;
  logic             sync;
  logic             dout_ack;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             busy;
  logic             overrun;
  logic [CW-1:0]    bit_cnt;

  modport master (
    output sin, sin_en, sync, dout_ack,
    input  dout, dout_valid, busy, overrun, bit_cnt
  );

  modport slave (
    input  sin, sin_en, sync, dout_ack,
    output dout, dout_valid, busy, overrun, bit_cnt
  );
endinterface

// File: rtl/sr_sipo_4bit_rx.sv
// Serial-in/parallel-out deserializer, MSB first, with a valid/ack holding register,
// sticky overrun flag and a sync input that realigns word boundaries.
module sr_sipo_4bit_rx #(
  parameter int unsigned WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  sr_sipo_4bit_rx_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic [CW-1:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [WIDTH-1:0] r_dout, w_dout_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_ovr, w_ovr_nxt;
  logic             r_busy;
  logic             w_complete;
  logic [WIDTH-1:0] w_word;

  assign w_word = {r_shreg[WIDTH-2:0], bus.sin};

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_dout    <= '0;
      r_valid   <= 1'b0;
      r_ovr     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_dout    <= w_dout_nxt;
      r_valid   <= w_valid_nxt;
      r_ovr     <= w_ovr_nxt;
      r_busy    <= (w_state_nxt == SHIFT);
    end
  end

  // Next-state, shift datapath and handshake
  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_bit_cnt_nxt = r_bit_cnt;
    w_dout_nxt    = r_dout;
    w_valid_nxt   = r_valid;
    w_ovr_nxt     = r_ovr;
    w_complete    = 1'b0;

    // sync drops the partial word; a same-cycle bit starts the next one
    if (bus.sync) begin
      w_shreg_nxt   = bus.sin_en ? WIDTH'(bus.sin) : '0;
      w_bit_cnt_nxt = bus.sin_en ? CW'(1) : '0;
      w_state_nxt   = bus.sin_en ? SHIFT : IDLE;
    end else if (bus.sin_en) begin
      unique case (r_state)
        IDLE: begin
          w_shreg_nxt   = WIDTH'(bus.sin);
          w_bit_cnt_nxt = CW'(1);
          w_state_nxt   = SHIFT;
        end
        SHIFT: begin
          if (r_bit_cnt == LAST_BIT) begin
            w_complete    = 1'b1;
            w_shreg_nxt   = '0;
            w_bit_cnt_nxt = '0;
            w_state_nxt   = IDLE;
          end else begin
            w_shreg_nxt   = w_word;
            w_bit_cnt_nxt = r_bit_cnt + CW'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end

    // A completed word always lands; overrun only if the old one was neither acked nor empty
    if (w_complete) begin
      w_dout_nxt  = w_word;
      w_valid_nxt = 1'b1;
      if (r_valid && !bus.dout_ack) begin
        w_ovr_nxt = 1'b1;
      end else if (bus.dout_ack) begin
        w_ovr_nxt = 1'b0;
      end
    end else if (bus.dout_ack) begin
      w_valid_nxt = 1'b0;
      w_ovr_nxt   = 1'b0;
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_valid;
  assign bus.busy       = r_busy;
  assign bus.overrun    = r_ovr;
  assign bus.bit_cnt    = r_bit_cnt;
endmodule
